aes_rd_writeback: RTL and testbench

//  Consumer (pop side) of the ID->AES rd-packet FIFO. Pops one id_rd_packet_t, waits for
//  the matching 32-bit AES unit result, and presents the {packet, result} pair on a

---
 rtl/aes_rd_writeback.sv | 145 ++++++++++++++
 tb/tb_aes_rd_writeback.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_rd_writeback.sv
// Pops rd packets from the ID->AES FIFO, pairs each with its AES result and
// issues the pair on a valid/ready write-back port. Optional AES_WB_STATS_EN.
package pkg;
  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] op;
    logic [7:0] tag;
  } id_rd_packet_t;
endpackage

module aes_rd_writeback
  import pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned STAT_WIDTH     = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  fifo_empty_i,
  input  id_rd_packet_t         fifo_data_i,
  output logic                  fifo_pop_o,
  input  logic                  res_valid_i,
  output logic                  res_ready_o,
  input  logic [31:0]           res_data_i,
  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output id_rd_packet_t         wb_packet_o,
  output logic [31:0]           wb_data_o,
  output logic                  busy_o,
  output logic                  err_o,
  output logic [STAT_WIDTH-1:0] wb_count_o
);

  localparam int unsigned TW =
    (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TW-1:0] TMO_LAST =
    TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMR_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RES,
    OUT
  } state_e;

  state_e        state_q, state_d;
  id_rd_packet_t pkt_q, pkt_d;
  logic [31:0]   res_q, res_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          err_q, err_d;
  logic          tmo_hit;

  assign tmo_hit = TMO_EN && (tmr_q == TMO_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pkt_q   <= '0;
      res_q   <= '0;
      tmr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      res_q   <= res_d;
      tmr_q   <= tmr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pkt_d       = pkt_q;
    res_d       = res_q;
    tmr_d       = tmr_q;
    err_d       = err_q;
    fifo_pop_o  = 1'b0;
    res_ready_o = 1'b0;
    wb_valid_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        fifo_pop_o = ~fifo_empty_i & ~flush_i;
        if (fifo_pop_o) begin
          pkt_d   = fifo_data_i;
          tmr_d   = '0;
          state_d = WAIT_RES;
        end
      end
      WAIT_RES: begin
        res_ready_o = ~flush_i;
        if (res_valid_i & res_ready_o) begin
          res_d   = res_data_i;
          state_d = OUT;
        end else begin
          if (tmo_hit) err_d = 1'b1;
          if (tmr_q != TMR_MAX) tmr_d = tmr_q + 1'b1;
        end
      end
      OUT: begin
        wb_valid_o = 1'b1;
        if (wb_ready_i) begin
          // back-to-back: refill from the FIFO on the retiring edge
          if (~fifo_empty_i & ~flush_i) begin
            fifo_pop_o = 1'b1;
            pkt_d      = fifo_data_i;
            tmr_d      = '0;
            state_d    = WAIT_RES;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d = IDLE;
      err_d   = 1'b0;
      tmr_d   = '0;
    end
  end

  assign wb_packet_o = pkt_q;
  assign wb_data_o   = res_q;
  assign busy_o      = (state_q != IDLE);
  assign err_o       = err_q;

`ifdef AES_WB_STATS_EN
  logic [STAT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (wb_valid_o & wb_ready_i & ~(&cnt_q)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign wb_count_o = cnt_q;
`else
  assign wb_count_o = '0;
`endif

endmodule

// File: tb/tb_aes_rd_writeback.sv
// Directed table-driven bench for aes_rd_writeback
// (TIMEOUT_CYCLES=4, STAT_WIDTH=2).
module tb_aes_rd_writeback;
  import pkg::*;

  typedef struct {
    logic        fl;
    logic        em;
    logic [15:0] fd;
    logic        rv;
    logic [31:0] rd;
    logic        wr;
    logic        pop;
    logic        rr;
    logic        wv;
    logic [15:0] pk;
    logic [31:0] dt;
    logic        bz;
    logic        er;
  } vec_t;

  localparam logic [15:0] PA = 16'h1A01;
  localparam logic [15:0] PB = 16'h2B02;
  localparam logic [15:0] PC = 16'h3C03;
  localparam logic [15:0] PD = 16'h4D04;
  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] R1 = 32'h11111111;
  localparam logic [31:0] R2 = 32'h22222222;
  localparam logic [31:0] R3 = 32'h33333333;
  localparam logic [31:0] R4 = 32'h44444444;
  localparam logic [31:0] R5 = 32'h55555555;
  localparam logic [31:0] R6 = 32'h66666666;
  localparam logic [31:0] R7 = 32'h77777777;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          flush_i = 1'b0;
  logic          fifo_empty_i = 1'b1;
  id_rd_packet_t fifo_data_i = '0;
  logic          fifo_pop_o;
  logic          res_valid_i = 1'b0;
  logic          res_ready_o;
  logic [31:0]   res_data_i = '0;
  logic          wb_valid_o;
  logic          wb_ready_i = 1'b0;
  id_rd_packet_t wb_packet_o;
  logic [31:0]   wb_data_o;
  logic          busy_o;
  logic          err_o;
  logic [1:0]    wb_count_o;

  int n_chk = 0;
  int n_err = 0;
  int cnt_exp = 0;
  vec_t tbl[$];

  aes_rd_writeback #(
    .TIMEOUT_CYCLES(4),
    .STAT_WIDTH    (2)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .fifo_empty_i(fifo_empty_i),
    .fifo_data_i (fifo_data_i),
    .fifo_pop_o  (fifo_pop_o),
    .res_valid_i (res_valid_i),
    .res_ready_o (res_ready_o),
    .res_data_i  (res_data_i),
    .wb_valid_o  (wb_valid_o),
    .wb_ready_i  (wb_ready_i),
    .wb_packet_o (wb_packet_o),
    .wb_data_o   (wb_data_o),
    .busy_o      (busy_o),
    .err_o       (err_o),
    .wb_count_o  (wb_count_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic vec_t mk(
    input logic fl, input logic em, input logic [15:0] fd,
    input logic rv, input logic [31:0] rd, input logic wr,
    input logic pop, input logic rr, input logic wv,
    input logic [15:0] pk, input logic [31:0] dt,
    input logic bz, input logic er);
    vec_t v;
    v.fl = fl; v.em = em; v.fd = fd;
    v.rv = rv; v.rd = rd; v.wr = wr;
    v.pop = pop; v.rr = rr; v.wv = wv;
    v.pk = pk; v.dt = dt; v.bz = bz; v.er = er;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int cnt_now();
`ifdef AES_WB_STATS_EN
    return cnt_exp;
`else
    return 0;
`endif
  endfunction

  task automatic chk_all(input int i, input vec_t v);
    chk($sformatf("r%0d pop", i), 32'(fifo_pop_o), 32'(v.pop));
    chk($sformatf("r%0d res_ready", i), 32'(res_ready_o), 32'(v.rr));
    chk($sformatf("r%0d wb_valid", i), 32'(wb_valid_o), 32'(v.wv));
    chk($sformatf("r%0d wb_packet", i), 32'(wb_packet_o), 32'(v.pk));
    chk($sformatf("r%0d wb_data", i), wb_data_o, v.dt);
    chk($sformatf("r%0d busy", i), 32'(busy_o), 32'(v.bz));
    chk($sformatf("r%0d err", i), 32'(err_o), 32'(v.er));
    chk($sformatf("r%0d count", i), 32'(wb_count_o), 32'(cnt_now()));
  endtask

  initial begin
    // single packet, fixed latency
    tbl.push_back(mk(0,0,PA,1,DB,1, 1,0,0,16'h0,32'h0,0,0));
    tbl.push_back(mk(0,1,16'h0,1,DB,1, 0,1,0,PA,32'h0,1,0));
    tbl.push_back(mk(0,1,16'h0,0,32'h0,1, 0,0,1,PA,DB,1,0));
    tbl.push_back(mk(0,1,16'h0,0,32'h0,1, 0,0,0,PA,DB,0,0));
    // backpressure for five cycles, then back-to-back refill
    tbl.push_back(mk(0,0,PB,1,R1,0, 1,0,0,PA,DB,0,0));
    tbl.push_back(mk(0,0,PC,1,R1,0, 0,1,0,PB,DB,1,0));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(0,0,PC,0,32'h0,0, 0,0,1,PB,R1,1,0));
    tbl.push_back(mk(0,0,PC,0,32'h0,1, 1,0,1,PB,R1,1,0));
    tbl.push_back(mk(0,0,PD,1,R2,1, 0,1,0,PC,R1,1,0));
    tbl.push_back(mk(0,0,PD,1,R3,1, 1,0,1,PC,R2,1,0));
    tbl.push_back(mk(0,1,16'h0,1,R3,1, 0,1,0,PD,R2,1,0));
    tbl.push_back(mk(0,1,16'h0,0,32'h0,1, 0,0,1,PD,R3,1,0));
    // watchdog: four cycles in WAIT_RES without a result
    tbl.push_back(mk(0,0,PA,0,32'h0,1, 1,0,0,PD,R3,0,0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0,1,16'h0,0,32'h0,1, 0,1,0,PA,R3,1,0));
    tbl.push_back(mk(0,1,16'h0,0,32'h0,1, 0,1,0,PA,R3,1,1));
    tbl.push_back(mk(0,1,16'h0,1,R4,0, 0,1,0,PA,R3,1,1));
    tbl.push_back(mk(0,1,16'h0,0,32'h0,0, 0,0,1,PA,R4,1,1));
    tbl.push_back(mk(0,1,16'h0,0,32'h0,1, 0,0,1,PA,R4,1,1));
    tbl.push_back(mk(0,1,16'h0,0,32'h0,1, 0,0,0,PA,R4,0,1));
    // flush in WAIT_RES clears err and blocks the accept
    tbl.push_back(mk(0,0,PB,0,32'h0,0, 1,0,0,PA,R4,0,1));
    tbl.push_back(mk(1,0,PC,1,R5,0, 0,0,0,PB,R4,1,1));
    tbl.push_back(mk(0,0,PC,0,32'h0,0, 1,0,0,PB,R4,0,0));
    // flush in OUT without handshake
    tbl.push_back(mk(0,1,16'h0,1,R6,0, 0,1,0,PC,R4,1,0));
    tbl.push_back(mk(0,1,16'h0,0,32'h0,0, 0,0,1,PC,R6,1,0));
    tbl.push_back(mk(1,0,PD,0,32'h0,0, 0,0,1,PC,R6,1,0));
    tbl.push_back(mk(0,1,16'h0,0,32'h0,0, 0,0,0,PC,R6,0,0));
    // flush coinciding with a handshake: counted, no refill
    tbl.push_back(mk(0,0,PD,0,32'h0,0, 1,0,0,PC,R6,0,0));
    tbl.push_back(mk(0,1,16'h0,1,R7,0, 0,1,0,PD,R6,1,0));
    tbl.push_back(mk(1,0,PA,0,32'h0,1, 0,0,1,PD,R7,1,0));
    tbl.push_back(mk(0,1,16'h0,0,32'h0,1, 0,0,0,PD,R7,0,0));

    // reset state
    repeat (2) @(negedge clk_i);
    chk("rst pop", 32'(fifo_pop_o), 32'h0);
    chk("rst wb_valid", 32'(wb_valid_o), 32'h0);
    chk("rst busy", 32'(busy_o), 32'h0);
    chk("rst err", 32'(err_o), 32'h0);
    chk("rst packet", 32'(wb_packet_o), 32'h0);
    chk("rst data", wb_data_o, 32'h0);
    chk("rst count", 32'(wb_count_o), 32'h0);
    rst_ni = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk_i);
      flush_i      = tbl[i].fl;
      fifo_empty_i = tbl[i].em;
      fifo_data_i  = id_rd_packet_t'(tbl[i].fd);
      res_valid_i  = tbl[i].rv;
      res_data_i   = tbl[i].rd;
      wb_ready_i   = tbl[i].wr;
      #2;
      chk_all(i, tbl[i]);
      @(posedge clk_i);
      if (tbl[i].wv && tbl[i].wr && cnt_exp < 3) cnt_exp++;
    end

    // asynchronous reset while a packet is in flight
    @(negedge clk_i);
    flush_i      = 1'b0;
    fifo_empty_i = 1'b0;
    fifo_data_i  = id_rd_packet_t'(PB);
    res_valid_i  = 1'b0;
    wb_ready_i   = 1'b0;
    @(negedge clk_i);
    fifo_empty_i = 1'b1;
    #1;
    chk("pre-rst busy", 32'(busy_o), 32'h1);
    chk("pre-rst packet", 32'(wb_packet_o), 32'(PB));
    #1 rst_ni = 1'b0;
    #1;
    chk("arst busy", 32'(busy_o), 32'h0);
    chk("arst res_ready", 32'(res_ready_o), 32'h0);
    chk("arst packet", 32'(wb_packet_o), 32'h0);
    chk("arst data", wb_data_o, 32'h0);
    chk("arst count", 32'(wb_count_o), 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    #1;
    chk("post-rst busy", 32'(busy_o), 32'h0);
    chk("post-rst wb_valid", 32'(wb_valid_o), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
